// File: rtl/serial_rx_deframer.sv
// -----------------------------------------------------------------------------
// serial_rx_deframer
//
// Receive side of a simple serial link. The idle-high line is synchronised,
// a start bit is detected and confirmed at its centre, then 8 data bits
// (MSB first) and a stop bit are sampled at bit centres. A good frame is
// presented on a valid/ack handshake; a bad stop bit pulses frame_error and
// the byte is dropped.
//
// Handshake: data_valid rises when a byte lands and stays high until a cycle
// with data_ack=1 and data_valid=1; that cycle consumes the byte. data_ack is
// ignored while data_valid=0. A byte landing while data_valid=1 without an
// ack in the same cycle overwrites data_byte and sets sticky overrun.
//
// Ports
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   rx_in        in   serial line, asynchronous to clock
//   data_ack     in   consumer accepts data_byte
//   data_byte    out  last good byte, first-received bit in [7]
//   data_valid   out  data_byte holds an unread byte
//   frame_error  out  one-cycle pulse on a low stop bit
//   overrun      out  sticky: an unread byte was overwritten
//   busy         out  FSM not idle
//   dbg_state    out  current FSM state encoding (debug visibility)
// -----------------------------------------------------------------------------
module serial_rx_deframer #(
  parameter int BIT_PERIOD = 106,
  parameter int CNT_W      = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_in,
  input  logic       data_ack,
  output logic [7:0] data_byte,
  output logic       data_valid,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_PERIOD - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_timer;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_data_byte;
  logic             r_data_valid;
  logic             r_frame_error;
  logic             r_overrun;

  logic             w_rx_s;
  logic             w_half_hit;
  logic             w_full_hit;
  logic             w_start_ok;
  logic             w_shift_en;
  logic             w_good_stop;
  logic             w_bad_stop;
  logic             w_busy;

  // Two-flop synchroniser; both flops reset to the idle (high) line level
  // so a reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s     = r_sync2;
  assign w_half_hit = (r_timer == HALF_M1);
  assign w_full_hit = (r_timer == FULL_M1);

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) w_next = S_START;
      end
      S_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (w_half_hit) w_next = w_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_full_hit && (r_bit_cnt == 4'd7)) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_full_hit) w_next = w_rx_s ? S_IDLE : S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // Hold here through a break so a stuck-low line is not re-framed.
        if (w_rx_s) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: output / strobe decode
  always_comb begin
    w_start_ok  = 1'b0;
    w_shift_en  = 1'b0;
    w_good_stop = 1'b0;
    w_bad_stop  = 1'b0;
    w_busy      = (r_state != S_IDLE);
    case (r_state)
      S_START: w_start_ok  = w_half_hit && !w_rx_s;
      S_DATA:  w_shift_en  = w_full_hit;
      S_STOP: begin
        w_good_stop = w_full_hit && w_rx_s;
        w_bad_stop  = w_full_hit && !w_rx_s;
      end
      default: ;
    endcase
  end

  // Bit timer: restarts on every sample point and is held at 0 when not
  // timing a bit, so it never needs to wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else begin
      case (r_state)
        S_START:        r_timer <= w_half_hit ? '0 : r_timer + 1'b1;
        S_DATA, S_STOP: r_timer <= w_full_hit ? '0 : r_timer + 1'b1;
        default:        r_timer <= '0;
      endcase
    end
  end

  // Bit counter and data shift register (MSB arrives first, so shifting into
  // the LSB leaves the first bit in [7] after eight samples).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
    end else begin
      if (w_start_ok) begin
        r_bit_cnt <= 4'd0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
        r_shift   <= {r_shift[6:0], w_rx_s};
      end
    end
  end

  // Output byte, handshake and status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data_byte   <= 8'h00;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_error <= w_bad_stop;
      if (w_good_stop) begin
        r_data_byte  <= r_shift;
        r_data_valid <= 1'b1;
        // An ack in the landing cycle consumes the old byte, so no overrun;
        // an existing overrun flag is left as is because no ack-only cycle
        // has happened.
        if (r_data_valid && !data_ack) r_overrun <= 1'b1;
      end else if (data_ack && r_data_valid) begin
        r_data_valid <= 1'b0;
        r_overrun    <= 1'b0;
      end
    end
  end

  assign data_byte   = r_data_byte;
  assign data_valid  = r_data_valid;
  assign frame_error = r_frame_error;
  assign overrun     = r_overrun;
  assign busy        = w_busy;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_serial_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_serial_rx_deframer
//
// Directed frames with hand-computed bytes. Each expected event (a newly
// presented byte, or a frame error pulse marked by bit 8) is queued when the
// frame is sent; a monitor pops and compares whenever the DUT presents one.
// -----------------------------------------------------------------------------
module tb_serial_rx_deframer;

  localparam int BP   = 106;
  localparam int HALF = BP / 2;
  localparam int LAT  = 2 + HALF + 9 * BP;

  logic       clock;
  logic       reset_n;
  logic       rx_in;
  logic       data_ack;
  logic [7:0] data_byte;
  logic       data_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;
  logic [2:0] dbg_state;

  logic [8:0] exp_q[$];
  int         vec_cnt;
  int         miss_cnt;
  int         cyc;
  int         t_fall;
  int         t_valid;
  logic       prev_valid;
  logic [7:0] prev_byte;

  serial_rx_deframer #(.BIT_PERIOD(BP), .CNT_W(10)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_in       (rx_in),
    .data_ack    (data_ack),
    .data_byte   (data_byte),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_byte  = 8'h00;
    end else begin
      if (data_valid && (!prev_valid || data_byte != prev_byte)) begin
        if (!prev_valid) t_valid = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {23'd0, 1'b0, data_byte}, 32'h1ff);
        end else begin
          check("rx_byte", {23'd0, 1'b0, data_byte}, {23'd0, exp_q.pop_front()});
        end
      end
      if (frame_error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame_error", 32'h100, 32'h1ff);
        end else begin
          check("frame_error_event", 32'h100, {23'd0, exp_q.pop_front()});
        end
      end
      prev_valid = data_valid;
      prev_byte  = data_byte;
    end
  end

  // ---------------- driver tasks ----------------
  // Sends start, 8 data bits MSB first, stop. Optionally pulses data_ack so
  // it is high across the stop-sample clock edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic ack_on_stop);
    int bi;
    for (int i = 0; i < 10 * BP; i++) begin
      @(negedge clock);
      bi = i / BP;
      if (i == 0) t_fall = cyc;
      if (bi == 0)      rx_in = 1'b0;
      else if (bi <= 8) rx_in = b[8 - bi];
      else              rx_in = stop_bit;
      if (ack_on_stop) data_ack = (i == LAT);
    end
    data_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      rx_in = 1'b1;
    end
  endtask

  task automatic ack_pulse();
    @(negedge clock);
    data_ack = 1'b1;
    @(negedge clock);
    data_ack = 1'b0;
  endtask

  // Bounded wait for the scoreboard to drain and the FSM to go idle.
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3 * BP) begin
      @(negedge clock);
      n++;
    end
    check(name, {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_cnt    = 0;
    miss_cnt   = 0;
    cyc        = 0;
    t_fall     = 0;
    t_valid    = 0;
    prev_valid = 1'b0;
    prev_byte  = 8'h00;
    rx_in      = 1'b1;
    data_ack   = 1'b0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", {19'd0, data_byte, data_valid, frame_error, overrun, busy, dbg_state}, 32'd0);
    reset_n = 1'b1;
    idle(5);

    // 1: frame 0xA5, latency and busy
    exp_q.push_back(9'h0A5);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(10);
    wait_drain("t1_drain");
    check("t1_byte", {24'd0, data_byte}, 32'hA5);
    check("t1_valid", {31'd0, data_valid}, 32'd1);
    check("t1_latency_ok", {31'd0, (t_valid - t_fall == LAT) || (t_valid - t_fall == LAT + 1)}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
    ack_pulse();
    check("t1_ack_clears", {31'd0, data_valid}, 32'd0);

    // ack while nothing valid is ignored
    ack_pulse();
    check("ack_idle_valid", {31'd0, data_valid}, 32'd0);

    // 2: short low glitch
    for (int i = 0; i < BP / 4; i++) begin
      @(negedge clock);
      rx_in = 1'b0;
    end
    idle(BP);
    wait_drain("t2_drain");
    check("t2_no_valid", {30'd0, data_valid, frame_error}, 32'd0);
    check("t2_state_idle", {29'd0, dbg_state}, 32'd0);

    // 3: bad stop, line held low a while, then a good frame
    exp_q.push_back(9'h100);
    send_frame(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 2 * BP; i++) begin
      @(negedge clock);
      rx_in = 1'b0;
    end
    check("t3_wait_hi_state", {29'd0, dbg_state}, 32'd4);
    idle(20);
    wait_drain("t3_err_drain");
    check("t3_no_valid", {31'd0, data_valid}, 32'd0);
    exp_q.push_back(9'h081);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(10);
    wait_drain("t3_good_drain");
    check("t3_byte", {24'd0, data_byte}, 32'h81);
    ack_pulse();

    // 4: overrun
    exp_q.push_back(9'h011);
    send_frame(8'h11, 1'b1, 1'b0);
    idle(20);
    exp_q.push_back(9'h022);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(10);
    wait_drain("t4_drain");
    check("t4_byte", {24'd0, data_byte}, 32'h22);
    check("t4_overrun", {31'd0, overrun}, 32'd1);
    check("t4_valid", {31'd0, data_valid}, 32'd1);
    ack_pulse();
    check("t4_ack_clears", {30'd0, data_valid, overrun}, 32'd0);

    // 5: ack on the stop-sample cycle of a second frame
    exp_q.push_back(9'h05A);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(20);
    exp_q.push_back(9'h0C3);
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(10);
    wait_drain("t5_drain");
    check("t5_byte", {24'd0, data_byte}, 32'hC3);
    check("t5_valid_no_overrun", {30'd0, data_valid, overrun}, 32'd2);

    // 6: reset during bit 4 (byte 0xC3 still unread going in)
    for (int i = 0; i < 5 * BP + HALF; i++) begin
      @(negedge clock);
      if (i < BP) rx_in = 1'b0;
      else        rx_in = ((i / BP) % 2 == 1);
    end
    check("t6_busy_before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_async_reset", {19'd0, data_byte, data_valid, frame_error, overrun, busy, dbg_state}, 32'd0);
    rx_in = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    idle(10);
    exp_q.push_back(9'h0FF);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(10);
    wait_drain("t6_drain");
    check("t6_byte", {24'd0, data_byte}, 32'hFF);
    check("t6_flags", {29'd0, data_valid, frame_error, overrun}, 32'd4);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
